// File: rtl/mips_io_responder.sv
// mips_io_responder: peripheral end of the MIPS 16-word I/O window.
// Seven-segment display logic is compiled in with MIPS_IO_SEVENSEG_EN.
module mips_io_responder #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOWriteData,
  input  logic [3:0]  IOAddr,
  input  logic        IOWriteEn,
  output logic [31:0] IOReadData,
  input  logic [7:0]  Switches,
  output logic [7:0]  LED,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        TimerIRQ
);

  localparam logic [3:0] A_LED  = 4'h0;
  localparam logic [3:0] A_SW   = 4'h1;
  localparam logic [3:0] A_DISP = 4'h2;
  localparam logic [3:0] A_CNT  = 4'h3;
  localparam logic [3:0] A_TMR  = 4'h4;
  localparam logic [3:0] A_STAT = 4'h5;

  logic [7:0]  led_q, led_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tmr_q, tmr_d;
  logic        flag_q, flag_d;
  logic        wr_led, wr_cnt, wr_tmr, wr_stat;
  logic        expire;
  logic [31:0] disp_rd;

  assign wr_led  = IOWriteEn && (IOAddr == A_LED);
  assign wr_cnt  = IOWriteEn && (IOAddr == A_CNT);
  assign wr_tmr  = IOWriteEn && (IOAddr == A_TMR);
  assign wr_stat = IOWriteEn && (IOAddr == A_STAT);

  always_comb begin
    led_d  = led_q;
    cnt_d  = cnt_q + 32'd1;
    tmr_d  = tmr_q;
    flag_d = flag_q;
    expire = 1'b0;
    if (wr_led) led_d = IOWriteData[7:0];
    if (wr_cnt) cnt_d = IOWriteData;
    if (wr_tmr) begin
      tmr_d = IOWriteData;
    end else if (tmr_q != 32'd0) begin
      tmr_d  = tmr_q - 32'd1;
      expire = (tmr_q == 32'd1);
    end
    // Expiry outranks a same-edge W1C so the event is never lost.
    if (expire) begin
      flag_d = 1'b1;
    end else if (wr_stat && IOWriteData[0]) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= Switches;
      sw_sync_q <= sw_meta_q;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      flag_q    <= flag_d;
    end
  end

`ifdef MIPS_IO_SEVENSEG_EN
  logic [15:0] disp_q, disp_d;
  logic [15:0] pre_q, pre_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  nib;
  logic        wr_disp;

  assign wr_disp = IOWriteEn && (IOAddr == A_DISP);

  always_comb begin
    disp_d = disp_q;
    pre_d  = pre_q + 16'd1;
    idx_d  = idx_q;
    if (wr_disp) disp_d = IOWriteData[15:0];
    if (pre_q == SCAN_DIV - 16'd1) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      disp_q <= '0;
      pre_q  <= '0;
      idx_q  <= '0;
    end else begin
      disp_q <= disp_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    nib = disp_q[3:0];
    unique case (1'b1)
      idx_q == 2'd0: nib = disp_q[3:0];
      idx_q == 2'd1: nib = disp_q[7:4];
      idx_q == 2'd2: nib = disp_q[11:8];
      idx_q == 2'd3: nib = disp_q[15:12];
      default:       nib = disp_q[3:0];
    endcase
  end

  // Segment order {g,f,e,d,c,b,a}, low = lit.
  always_comb begin
    SEG = 7'b1111111;
    case (nib)
      4'h0: SEG = 7'b1000000;
      4'h1: SEG = 7'b1111001;
      4'h2: SEG = 7'b0100100;
      4'h3: SEG = 7'b0110000;
      4'h4: SEG = 7'b0011001;
      4'h5: SEG = 7'b0010010;
      4'h6: SEG = 7'b0000010;
      4'h7: SEG = 7'b1111000;
      4'h8: SEG = 7'b0000000;
      4'h9: SEG = 7'b0010000;
      4'hA: SEG = 7'b0001000;
      4'hB: SEG = 7'b0000011;
      4'hC: SEG = 7'b1000110;
      4'hD: SEG = 7'b0100001;
      4'hE: SEG = 7'b0000110;
      4'hF: SEG = 7'b0001110;
      default: SEG = 7'b1111111;
    endcase
  end

  assign AN      = ~(4'b0001 << idx_q);
  assign disp_rd = {16'h0000, disp_q};
`else
  logic unused_div;

  assign unused_div = ^SCAN_DIV;
  assign AN         = 4'b1111;
  assign SEG        = 7'b1111111;
  assign disp_rd    = '0;
`endif

  always_comb begin
    IOReadData = '0;
    case (IOAddr)
      A_LED:   IOReadData = {24'h0, led_q};
      A_SW:    IOReadData = {24'h0, sw_sync_q};
      A_DISP:  IOReadData = disp_rd;
      A_CNT:   IOReadData = cnt_q;
      A_TMR:   IOReadData = tmr_q;
      A_STAT:  IOReadData = {31'h0, flag_q};
      default: IOReadData = '0;
    endcase
  end

  assign LED      = led_q;
  assign TimerIRQ = flag_q;

endmodule
